// File: rtl/tri_st_add_csel_seq.sv
// Byte-serial carry-select resolver.
// Takes per-byte conditional sums plus group generate/transmit, LSB byte first.
// Picks each byte's final sum from the running carry and registers one result byte per beat.
module tri_st_add_csel_seq #(
    parameter int unsigned BYTES = 8
) (
    input  logic       nclk,
    input  logic       rst,
    input  logic       in_val,
    output logic       in_rdy,
    input  logic       in_first,
    input  logic       in_last,
    input  logic       in_ci,
    input  logic [0:7] in_sum_0,
    input  logic [0:7] in_sum_1,
    input  logic       in_g08,
    input  logic       in_t08,
    output logic       out_val,
    input  logic       out_rdy,
    output logic [0:7] out_sum,
    output logic       out_last,
    output logic       out_co,
    output logic       out_err
);

    localparam int unsigned CW = $clog2(BYTES + 1);
    localparam logic [CW-1:0] BytesC = CW'(BYTES);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          carry_q;

    logic          accept;
    logic          start;
    logic          cin_eff;
    logic          carry_nxt;
    logic [CW-1:0] cnt_inc;
    logic          overrun;
    logic          last_nxt;
    logic          err_nxt;
    logic [0:7]    sum_nxt;

    // Single output register, no skid: accept whenever the register is empty or draining.
    assign in_rdy = ~rst & (~out_val | out_rdy);
    assign accept = in_val & in_rdy;

    // State register.
    always_ff @(posedge nclk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: an accepted beat either closes the operation or leaves it open.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (accept) begin
            state_d = last_nxt ? StIdle : StBusy;
            count_d = last_nxt ? '0 : cnt_inc;
        end
    end

    // Beat decode: carry select, carry update and per-byte flags for the accepted beat.
    always_comb begin
        // A beat in IDLE always starts an operation, even without in_first.
        start     = (state_q == StIdle) | in_first;
        cin_eff   = start ? in_ci : carry_q;
        sum_nxt   = cin_eff ? in_sum_1 : in_sum_0;
        carry_nxt = in_g08 | (in_t08 & cin_eff);
        cnt_inc   = start ? CW'(1) : count_q + CW'(1);
        overrun   = ~in_last & (cnt_inc == BytesC);
        last_nxt  = in_last | overrun;
        err_nxt   = ((state_q == StIdle) & ~in_first) |
                    ((state_q == StBusy) & in_first) |
                    overrun;
    end

    // Carry, count and output byte registers; outputs hold while stalled.
    always_ff @(posedge nclk) begin
        if (rst) begin
            count_q  <= '0;
            carry_q  <= 1'b0;
            out_val  <= 1'b0;
            out_sum  <= '0;
            out_last <= 1'b0;
            out_co   <= 1'b0;
            out_err  <= 1'b0;
        end else if (accept) begin
            count_q  <= count_d;
            carry_q  <= carry_nxt;
            out_val  <= 1'b1;
            out_sum  <= sum_nxt;
            out_last <= last_nxt;
            out_co   <= last_nxt & carry_nxt;
            out_err  <= err_nxt;
        end else if (out_rdy) begin
            out_val  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tri_st_add_csel_seq.sv
// Bench for tri_st_add_csel_seq with BYTES=2: table vectors plus reset/backpressure sequences.
module tb_tri_st_add_csel_seq;

    logic       nclk;
    logic       rst;
    logic       in_val;
    logic       in_rdy;
    logic       in_first;
    logic       in_last;
    logic       in_ci;
    logic [0:7] in_sum_0;
    logic [0:7] in_sum_1;
    logic       in_g08;
    logic       in_t08;
    logic       out_val;
    logic       out_rdy;
    logic [0:7] out_sum;
    logic       out_last;
    logic       out_co;
    logic       out_err;

    tri_st_add_csel_seq #(.BYTES(2)) dut (
        .nclk     (nclk),
        .rst      (rst),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in_first (in_first),
        .in_last  (in_last),
        .in_ci    (in_ci),
        .in_sum_0 (in_sum_0),
        .in_sum_1 (in_sum_1),
        .in_g08   (in_g08),
        .in_t08   (in_t08),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_sum  (out_sum),
        .out_last (out_last),
        .out_co   (out_co),
        .out_err  (out_err)
    );

    initial nclk = 1'b0;
    always #5 nclk = ~nclk;

    typedef struct packed {
        logic       first;
        logic       last;
        logic       ci;
        logic [7:0] s0;
        logic [7:0] s1;
        logic       g;
        logic       t;
        logic [7:0] esum;
        logic       elast;
        logic       eco;
        logic       eerr;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    logic [10:0] sb [$];
    int n_cmp;
    int n_bad;
    bit rnd_rdy;

    task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        in_first = v.first;
        in_last  = v.last;
        in_ci    = v.ci;
        in_sum_0 = v.s0;
        in_sum_1 = v.s1;
        in_g08   = v.g;
        in_t08   = v.t;
    endtask

    // Called at posedge+#1; returns at posedge+#1 after the beat has been accepted.
    task automatic send_beat(input vec_t v);
        bit done;
        done = 1'b0;
        drive(v);
        in_val = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge nclk);
            if (in_rdy) begin
                sb.push_back({v.esum, v.elast, v.eco, v.eerr});
                done = 1'b1;
            end
            @(posedge nclk);
            #1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: in_rdy never rose, got 0 expected 1");
        end
    endtask

    task automatic drain();
        in_val = 1'b0;
        for (int i = 0; i < 64 && sb.size() != 0; i++) begin
            @(posedge nclk);
            #1;
        end
        check("drain_empty", 11'(sb.size()), 11'd0);
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rnd_rdy = 1'b0;
        rst     = 1'b1;
        out_rdy = 1'b1;
        in_val  = 1'b0;
        drive('0);

        // first  last ci  s0     s1     g     t     esum   last  co    err
        // 0x12FF + 0x0001, ci=0
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h12, 8'h13, 1'b0, 1'b0, 8'h13, 1'b1, 1'b0, 1'b0};
        // 0xFFFF + 0, ci=1 then ci=0
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        // single-byte op then two-byte op, each with its own ci; non-first ci ignored
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 8'h10, 8'h11, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'h20, 8'h21, 1'b0, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 8'h30, 8'h31, 1'b1, 1'b1, 8'h30, 1'b1, 1'b1, 1'b0};
        // overrun: byte 1 forced last with err; third beat starts in IDLE with err
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'h01, 8'h02, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h03, 8'h04, 1'b0, 1'b1, 8'h04, 1'b1, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h05, 8'h06, 1'b0, 1'b0, 8'h06, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 8'h07, 8'h08, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0};
        // restart in BUSY: carry comes from in_ci, not the pending carry of 1
        vecs[13] = '{1'b1, 1'b0, 1'b0, 8'h40, 8'h41, 1'b1, 1'b1, 8'h40, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 8'h50, 8'h51, 1'b0, 1'b0, 8'h50, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 8'h60, 8'h61, 1'b0, 1'b1, 8'h60, 1'b1, 1'b0, 1'b0};
        // single-byte op with in_first=0 in IDLE
        vecs[16] = '{1'b0, 1'b1, 1'b1, 8'h70, 8'h71, 1'b1, 1'b1, 8'h71, 1'b1, 1'b1, 1'b1};
        // single-byte op, carry-out from transmit with ci=0 is 0
        vecs[17] = '{1'b1, 1'b1, 1'b0, 8'h80, 8'h81, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0};

        fork
            // Scoreboard monitor: every output handshake pops one expected byte.
            forever begin
                @(negedge nclk);
                if (!rst && out_val && out_rdy) begin
                    if (sb.size() == 0) begin
                        check("out_unexpected", {out_sum, out_last, out_co, out_err}, 11'h7FF);
                    end else begin
                        check("out_byte", {out_sum, out_last, out_co, out_err}, sb.pop_front());
                    end
                end
            end
            // Random downstream backpressure when enabled.
            forever begin
                @(posedge nclk);
                #1;
                if (rnd_rdy) out_rdy = 1'($urandom_range(0, 1));
            end
        join_none

        // Reset state
        repeat (2) @(posedge nclk);
        #1;
        @(negedge nclk);
        check("reset_in_rdy", 11'(in_rdy), 11'd0);
        check("reset_outs", {out_sum, out_val, out_last, out_co}, 11'd0);
        check("reset_err", 11'(out_err), 11'd0);
        @(posedge nclk);
        #1;
        rst = 1'b0;

        // Table pass at full throughput, then with random backpressure
        for (int pass = 0; pass < 2; pass++) begin
            rnd_rdy = (pass == 1);
            for (int i = 0; i < NV; i++) send_beat(vecs[i]);
            drain();
            rnd_rdy = 1'b0;
            out_rdy = 1'b1;
            drain();
        end

        // Backpressure: stall 3 cycles after the first output byte
        out_rdy = 1'b0;
        send_beat(vecs[0]);
        drive(vecs[1]);
        in_val = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge nclk);
            check("bp_hold", {out_sum, out_val, in_rdy, 1'b0}, {8'h00, 1'b1, 1'b0, 1'b0});
            @(posedge nclk);
            #1;
        end
        out_rdy = 1'b1;
        send_beat(vecs[1]);
        in_val = 1'b0;
        @(negedge nclk);
        check("bp_release", {out_sum, out_val, out_last, 1'b0}, {8'h13, 1'b1, 1'b1, 1'b0});
        @(posedge nclk);
        #1;
        drain();

        // Reset mid-operation after a carry-generating first byte
        out_rdy = 1'b0;
        send_beat('{1'b1, 1'b0, 1'b1, 8'hFE, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0});
        rst = 1'b1;
        @(negedge nclk);
        check("rst_in_rdy", 11'(in_rdy), 11'd0);
        @(posedge nclk);
        #1;
        @(negedge nclk);
        check("rst_outs", {out_sum, out_val, out_last, out_co}, 11'd0);
        check("rst_err", 11'(out_err), 11'd0);
        sb.delete();
        @(posedge nclk);
        #1;
        rst     = 1'b0;
        out_rdy = 1'b1;
        send_beat('{1'b1, 1'b1, 1'b0, 8'hAA, 8'hAB, 1'b0, 1'b0, 8'hAA, 1'b1, 1'b0, 1'b0});
        drain();

        // Idle with out_rdy=1 drops out_val
        @(negedge nclk);
        check("idle_out_val", 11'(out_val), 11'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
